// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues single-outstanding fetches and buffers responses in a 2-entry FIFO.
// Defining FETCH_PERF_CNT_EN adds the saturating fetchCount/stallCount counters and their ports.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCSrc,
  input  logic [31:0] branchTarget,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic        validOut,
  output logic [31:0] pcOut,
  output logic [31:0] instructionOut
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetchCount,
  output logic [31:0] stallCount
`endif
);

  localparam int            CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_ISSUE,
    ST_WAIT,
    ST_FLUSH
  } state_e;

  state_e                     state_q, state_d;
  logic [31:0]                fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]              count_q, count_d;
  logic [DEPTH-1:0][31:0]     ent_pc_q, ent_pc_d;
  logic [DEPTH-1:0][31:0]     ent_ins_q, ent_ins_d;

  logic          issue;
  logic          push;
  logic          pop;
  logic [31:0]   push_pc;
  logic [CW-1:0] slot_after_pop;

  // A request only goes out when the response is guaranteed a free slot.
  assign issue          = (state_q == ST_ISSUE) && (count_q != FULL) && !reset;
  assign push           = (state_q == ST_WAIT) && imem_valid && !PCSrc;
  assign pop            = (count_q != '0) && !stall;
  assign push_pc        = fetch_pc_q + 32'd4;
  assign slot_after_pop = count_q - CW'(pop);

  assign imem_req       = issue;
  assign imem_addr      = fetch_pc_q;
  assign validOut       = (count_q != '0);
  assign pcOut          = ent_pc_q[0];
  assign instructionOut = ent_ins_q[0];

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      ST_ISSUE: begin
        if (issue) state_d = PCSrc ? ST_FLUSH : ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_valid) begin
          state_d = ST_ISSUE;
          if (!PCSrc) fetch_pc_d = push_pc;
        end else if (PCSrc) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (imem_valid) state_d = ST_ISSUE;
      end
      default: state_d = ST_ISSUE;
    endcase
    if (PCSrc) fetch_pc_d = branchTarget & ~32'h3;
  end

  always_comb begin
    count_d = count_q + CW'(push) - CW'(pop);
    if (PCSrc) count_d = '0;
  end

  // Entry gi takes the new word when it is the first free slot after this
  // cycle's pop, otherwise shifts down from gi+1; an emptied head keeps its value.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic        load_new;
    logic        load_shift;
    logic [31:0] up_pc;
    logic [31:0] up_ins;
    if (gi < DEPTH - 1) begin : g_up
      assign up_pc  = ent_pc_q[gi+1];
      assign up_ins = ent_ins_q[gi+1];
    end else begin : g_top
      assign up_pc  = ent_pc_q[gi];
      assign up_ins = ent_ins_q[gi];
    end
    assign load_new      = push && (slot_after_pop == CW'(gi));
    assign load_shift    = pop && !PCSrc && (CW'(gi + 1) < count_q);
    assign ent_pc_d[gi]  = load_new ? push_pc : (load_shift ? up_pc : ent_pc_q[gi]);
    assign ent_ins_d[gi] = load_new ? imem_rdata : (load_shift ? up_ins : ent_ins_q[gi]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_ISSUE;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      ent_pc_q   <= '0;
      ent_ins_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      ent_pc_q   <= ent_pc_d;
      ent_ins_q  <= ent_ins_d;
    end
  end

  a_no_push_when_full : assert property (@(posedge clk) disable iff (reset)
    !(push && (count_q == FULL)));

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (pop && (fetch_cnt_q != 32'hFFFF_FFFF)) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (validOut && stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetchCount = fetch_cnt_q;
  assign stallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: cycle vectors, redirect/reset sequences and a randomized run
// checked against an instruction-stream scoreboard fed by a variable-latency memory model.
`timescale 1ns/1ps
module tb_fetch_stage;

  localparam logic [31:0] TAG  = 32'hA000_0000;
  localparam logic [31:0] RPC1 = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, PCSrc, stall, imem_valid;
  logic [31:0] branchTarget, imem_rdata;
  logic        imem_req, validOut;
  logic [31:0] imem_addr, pcOut, instructionOut;

  logic        req1, valid1, mvalid1;
  logic [31:0] addr1, pc1, ins1, mrdata1;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetchCount, stallCount, fc1, sc1;
  int unsigned fc_exp, sc_exp;
`endif

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .PCSrc(PCSrc), .branchTarget(branchTarget), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .validOut(validOut), .pcOut(pcOut), .instructionOut(instructionOut)
`ifdef FETCH_PERF_CNT_EN
    , .fetchCount(fetchCount), .stallCount(stallCount)
`endif
  );

  fetch_stage #(.RESET_PC(RPC1)) dut1 (
    .clk(clk), .reset(reset), .PCSrc(1'b0), .branchTarget(32'h0), .stall(1'b0),
    .imem_req(req1), .imem_addr(addr1), .imem_rdata(mrdata1), .imem_valid(mvalid1),
    .validOut(valid1), .pcOut(pc1), .instructionOut(ins1)
`ifdef FETCH_PERF_CNT_EN
    , .fetchCount(fc1), .stallCount(sc1)
`endif
  );

  // Fixed 1-cycle memory for the wrap-around instance.
  always @(posedge clk) begin
    if (reset) begin
      mvalid1 <= 1'b0;
      mrdata1 <= 32'h0;
    end else begin
      mvalid1 <= req1;
      mrdata1 <= addr1 | TAG;
    end
  end

  int          checks = 0, failures = 0;
  int          cyc = 0, lat = 1;
  bit          pend = 0;
  int          pend_due = 0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] exp_pc = 32'h0;
  int          gap = 0, n_del = 0;
  logic [31:0] watch_addr = 32'hFFFF_FFFF;
  int          watch_hits = 0;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_ins;
  bit          d1_cap = 0;
  int          d1_nreq = 0, d1_ndel = 0;
  logic [31:0] d1_req[3], d1_pc[3], d1_ins[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, req, cyc);
    end
  endtask

  // One clock cycle: present memory response, sample at negedge, update models.
  task automatic tick();
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    if (reset) pend = 0;
    else if (pend && pend_due == cyc) begin
      imem_valid = 1'b1;
      imem_rdata = pend_addr | TAG;
      pend = 0;
    end
    @(negedge clk);
    s_req = imem_req; s_addr = imem_addr; s_valid = validOut; s_pc = pcOut; s_ins = instructionOut;
    if (reset) begin
      check("req_in_reset", {31'b0, imem_req}, 32'd0);
      exp_pc = 32'h0;
      gap = 0;
`ifdef FETCH_PERF_CNT_EN
      fc_exp = 0;
      sc_exp = 0;
`endif
    end else begin
      if (imem_req) begin
        check("single_outstanding", {31'b0, pend}, 32'd0);
        pend = 1; pend_due = cyc + lat; pend_addr = imem_addr;
        if (imem_addr == watch_addr) watch_hits++;
      end
      if (validOut && !stall) begin
        check("deliver_pc", pcOut, exp_pc + 32'd4);
        check("deliver_ins", instructionOut, exp_pc | TAG);
        exp_pc = exp_pc + 32'd4;
        n_del++;
      end
      if (PCSrc) exp_pc = branchTarget & ~32'h3;
      gap = (validOut || PCSrc) ? 0 : gap + 1;
      check("liveness_gap_le16", {31'b0, gap <= 16}, 32'd1);
      if (gap > 16) gap = 0;
`ifdef FETCH_PERF_CNT_EN
      check("fetchCount", fetchCount, fc_exp);
      check("stallCount", stallCount, sc_exp);
      if (validOut && !stall) fc_exp++;
      if (validOut && stall) sc_exp++;
`endif
      if (d1_cap) begin
        if (req1 && d1_nreq < 3) begin d1_req[d1_nreq] = addr1; d1_nreq++; end
        if (valid1 && d1_ndel < 3) begin d1_pc[d1_ndel] = pc1; d1_ins[d1_ndel] = ins1; d1_ndel++; end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1; PCSrc = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic run_until_req(input string name, output logic [31:0] a);
    a = 32'hDEAD_DEAD;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (s_req) begin a = s_addr; return; end
    end
    check({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic run_until_valid(input string name, output logic [31:0] p);
    p = 32'hDEAD_DEAD;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (s_valid) begin p = s_pc; return; end
    end
    check({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  typedef struct {
    logic        rst, stl, ck, e_req, e_val;
    logic [31:0] e_addr, e_pc, e_ins;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic rst, stl, ck, e_req, input logic [31:0] e_addr,
                     input logic e_val, input logic [31:0] e_pc, e_ins);
    vec_t v;
    v.rst = rst; v.stl = stl; v.ck = ck; v.e_req = e_req; v.e_addr = e_addr;
    v.e_val = e_val; v.e_pc = e_pc; v.e_ins = e_ins;
    tbl.push_back(v);
  endtask

  logic [31:0] a, p;
  logic [31:0] d1_req_exp[3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
  logic [31:0] d1_pc_exp[3]  = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
  logic [31:0] d1_ins_exp[3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'hA000_0000};

  initial begin
    reset = 1'b1; PCSrc = 1'b0; stall = 1'b0; branchTarget = 32'h0;
    imem_valid = 1'b0; imem_rdata = 32'h0;

    // Steady fetch at latency 1, then a 10-cycle stall filling the FIFO.
    add(1, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0);
    add(1, 0, 1, 0, 32'h0, 0, 32'h0, 32'h0);
    add(0, 0, 1, 1, 32'h0, 0, 32'h0, 32'h0);
    add(0, 0, 1, 0, 32'h0, 0, 32'h0, 32'h0);
    add(0, 0, 1, 1, 32'h4, 1, 32'h4, 32'hA000_0000);
    add(0, 0, 1, 0, 32'h0, 0, 32'h4, 32'hA000_0000);
    add(0, 0, 1, 1, 32'h8, 1, 32'h8, 32'hA000_0004);
    add(0, 0, 1, 0, 32'h0, 0, 32'h8, 32'hA000_0004);
    add(0, 0, 1, 1, 32'hC, 1, 32'hC, 32'hA000_0008);
    add(1, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0);
    add(1, 1, 1, 0, 32'h0, 0, 32'h0, 32'h0);
    add(0, 1, 1, 1, 32'h0, 0, 32'h0, 32'h0);
    add(0, 1, 1, 0, 32'h0, 0, 32'h0, 32'h0);
    add(0, 1, 1, 1, 32'h4, 1, 32'h4, 32'hA000_0000);
    add(0, 1, 1, 0, 32'h0, 1, 32'h4, 32'hA000_0000);
    for (int i = 0; i < 6; i++) add(0, 1, 1, 0, 32'h0, 1, 32'h4, 32'hA000_0000);
    add(0, 0, 1, 0, 32'h0, 1, 32'h4, 32'hA000_0000);
    add(0, 0, 1, 1, 32'h8, 1, 32'h8, 32'hA000_0004);
    add(0, 0, 1, 0, 32'h0, 0, 32'h8, 32'hA000_0004);
    add(0, 0, 1, 1, 32'hC, 1, 32'hC, 32'hA000_0008);

    @(posedge clk);
    #1;
    d1_cap = 1;
    foreach (tbl[k]) begin
      reset = tbl[k].rst; stall = tbl[k].stl; PCSrc = 1'b0;
      tick();
      $display("vec %0d: req=%b addr=%h valid=%b pc=%h ins=%h", k, s_req, s_addr, s_valid, s_pc, s_ins);
      check("tbl_req", {31'b0, s_req}, {31'b0, tbl[k].e_req});
      if (tbl[k].e_req) check("tbl_addr", s_addr, tbl[k].e_addr);
      if (tbl[k].ck) begin
        check("tbl_valid", {31'b0, s_valid}, {31'b0, tbl[k].e_val});
        check("tbl_pc", s_pc, tbl[k].e_pc);
        check("tbl_ins", s_ins, tbl[k].e_ins);
      end
    end
    stall = 1'b0;

    // Wrap-around instance captured after the first reset.
    for (int i = 0; i < 3; i++) begin
      check($sformatf("wrap_req%0d", i), d1_req[i], d1_req_exp[i]);
      check($sformatf("wrap_pc%0d", i), d1_pc[i], d1_pc_exp[i]);
      check($sformatf("wrap_ins%0d", i), d1_ins[i], d1_ins_exp[i]);
    end
    $display("seq wrap: req %h %h %h pc %h %h %h", d1_req[0], d1_req[1], d1_req[2], d1_pc[0], d1_pc[1], d1_pc[2]);

    // Redirect during WAIT with 3-cycle memory.
    lat = 3; do_reset();
    tick();
    PCSrc = 1'b1; branchTarget = 32'h0000_0103;
    tick();
    PCSrc = 1'b0;
    run_until_req("redir_wait_req", a);
    check("redir_wait_addr", a, 32'h100);
    run_until_valid("redir_wait_valid", p);
    check("redir_wait_pc", p, 32'h104);
    $display("seq redirect-in-wait: next addr=%h first pc=%h", a, p);

    // Redirect coincident with the response.
    lat = 1; do_reset();
    tick();
    watch_addr = 32'h200; watch_hits = 0;
    PCSrc = 1'b1; branchTarget = 32'h200;
    tick();
    PCSrc = 1'b0;
    tick();
    check("redir_valid_dropped", {31'b0, s_valid}, 32'd0);
    check("redir_valid_req", {31'b0, s_req}, 32'd1);
    check("redir_valid_addr", s_addr, 32'h200);
    run_until_valid("redir_valid_valid", p);
    check("redir_valid_pc", p, 32'h204);
    for (int i = 0; i < 6; i++) tick();
    check("redir_valid_hits", watch_hits, 32'd1);
    $display("seq redirect-with-valid: first pc=%h hits=%0d", p, watch_hits);

    // Redirect while in ISSUE.
    do_reset();
    watch_addr = 32'h300; watch_hits = 0;
    PCSrc = 1'b1; branchTarget = 32'h302;
    tick();
    PCSrc = 1'b0;
    check("redir_issue_req", {31'b0, s_req}, 32'd1);
    check("redir_issue_addr", s_addr, 32'h0);
    tick();
    check("redir_issue_drop", {31'b0, s_valid}, 32'd0);
    run_until_valid("redir_issue_valid", p);
    check("redir_issue_pc", p, 32'h304);
    for (int i = 0; i < 6; i++) tick();
    check("redir_issue_hits", watch_hits, 32'd1);
    $display("seq redirect-in-issue: first pc=%h hits=%0d", p, watch_hits);
    watch_addr = 32'hFFFF_FFFF;

    // Reset while a fetch is outstanding and the FIFO holds an entry.
    lat = 3; stall = 1'b1; do_reset();
    for (int i = 0; i < 5; i++) tick();
    check("rst_mid_valid_before", {31'b0, s_valid}, 32'd1);
    check("rst_mid_req_before", {31'b0, s_req}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0; stall = 1'b0;
    tick();
    check("rst_mid_valid", {31'b0, s_valid}, 32'd0);
    check("rst_mid_pc", s_pc, 32'h0);
    check("rst_mid_req", {31'b0, s_req}, 32'd1);
    check("rst_mid_addr", s_addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_mid_fc", fetchCount, 32'd0);
    check("rst_mid_sc", stallCount, 32'd0);
    check("rst_mid_fc1", fc1, 32'd0);
    check("rst_mid_sc1", sc1, 32'd0);
`endif
    $display("seq reset-mid-wait: valid=%b req=%b addr=%h", s_valid, s_req, s_addr);

    // Randomized traffic against the stream scoreboard.
    lat = 1; do_reset();
    n_del = 0;
    for (int i = 0; i < 3000; i++) begin
      stall        = ($urandom_range(0, 99) < 30);
      PCSrc        = ($urandom_range(0, 99) < 5);
      branchTarget = $urandom_range(0, 32'hFFF);
      lat          = $urandom_range(1, 4);
      reset        = ($urandom_range(0, 999) < 5);
      tick();
    end
    reset = 1'b0; PCSrc = 1'b0; stall = 1'b0;
    check("random_progress", {31'b0, n_del > 200}, 32'd1);
    $display("seq random: delivered=%0d", n_del);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
